mdu_arbiter: RTL and testbench
==============================

Name: mdu_arbiter

Overview:
Shares one multiply_n_divide_top instance (64-bit operands, 129-bit result, start/ready handshake, m_d=1 multiply, m_d=0 divide) among NUM_REQ requesters. The block arbitrates round-robin, latches operands and sequences the unit's start/ready handshake. It returns a tagged result through a one-entry response register with backpressure. Divide-by-zero is resolved locally without occupying the unit.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester tag; must equal ceil(log2(NUM_REQ))
XLEN, 64, operand width; result width is 2*XLEN+1

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
req_valid  in  NUM_REQ  per-requester request pending
req_ready  out  NUM_REQ  one-hot accept pulse; handshake completes when valid&ready
req_a  in  NUM_REQ*XLEN  packed operand A; requester i at [i*XLEN +: XLEN]
req_b  in  NUM_REQ*XLEN  packed operand B, same packing
req_m_d  in  NUM_REQ  op select per requester: 1=multiply, 0=divide
mdu_a  out  XLEN  operand A to unit
mdu_b  out  XLEN  operand B to unit
mdu_m_d  out  1  op select to unit
mdu_start  out  1  start strobe to unit
mdu_result  in  2*XLEN+1  unit result; divide: quotient [XLEN-1:0], remainder [2*XLEN:XLEN]
mdu_ready  in  1  unit idle/result valid
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  ID_W  requester tag of response
rsp_result  out  2*XLEN+1  result
rsp_dz  out  1  response came from divide-by-zero bypass
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; rr_ptr=NUM_REQ-1; req_ready=0, mdu_start=0, mdu_a/b/m_d=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_dz=0, busy=0. An in-flight unit result is discarded.
- States: IDLE, ISSUE, ARM, WAIT, RESP.
- IDLE: grant the first i with req_valid[i]=1, searching from rr_ptr+1 upward with wrap. req_ready[grant]=1 combinationally in that cycle only. All other req_ready bits stay 0 in every state.
- On accept: latch a, b, m_d and id; rr_ptr<=grant.
  - If m_d=0 and b=0, go to RESP: rsp_result={1'b0, a, all-ones}, meaning remainder=a and quotient=2^XLEN-1; rsp_dz=1.
  - Otherwise go to ISSUE.
- ISSUE: mdu_start=1 for exactly this one cycle. mdu_a/b/m_d hold the latched values from ISSUE through the end of WAIT. Next state is ARM.
- ARM: one cycle in which mdu_ready is ignored, to cover the unit's ready-deassert latency. Next state is WAIT.
- WAIT: on the first cycle with mdu_ready=1, capture mdu_result into rsp_result unchanged, with rsp_dz=0, and go to RESP.
- RESP: rsp_valid=1. rsp_id, rsp_result and rsp_dz are stable while rsp_valid=1 and rsp_ready=0. When rsp_valid&rsp_ready, go to IDLE. The next grant occurs in the cycle after that; there is no same-cycle re-grant.
- Minimum occupancy per unit operation: accept, ISSUE, ARM, WAIT (n cycles), RESP (1 or more) → at least 5 cycles from accept to the next possible accept.
- Divide-by-zero bypass: accept → RESP in the next cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other grants.
- req_valid dropping before req_ready does not corrupt state; that request is simply not granted.
- Only one operation is outstanding; mdu_start is never asserted outside ISSUE.

Test Plan:
1. Single request: req0 multiply a=3, b=7 → one mdu_start pulse; rsp_id=0, rsp_result=21, rsp_dz=0.
2. Divide: req2 a=100, b=7 → rsp_id=2, quotient=14, remainder=2.
3. Divide-by-zero: req1 a=55, b=0, m_d=0 → mdu_start never asserted; rsp_result quotient=64'hFFFF_FFFF_FFFF_FFFF, remainder=55, rsp_dz=1, one cycle after accept.
4. Contention: all four requesters valid continuously, each with distinct operands → grant order 0,1,2,3,0,1; each response id matches and each result equals the software model (a*b, or a/b and a%b).
5. Backpressure: rsp_ready held 0 for 10 cycles in RESP → rsp_valid/id/result stable, no new req_ready and no mdu_start until rsp_ready=1.
6. Reset mid-WAIT: assert reset for 1 cycle while the unit is busy → busy=0 and rsp_valid=0 immediately; a new request afterwards completes correctly with a=2^32, b=2^32 → rsp_result=2^64.

Source files
------------

// File: rtl/mdu_arbiter_if.sv
// Requester, multiply/divide unit and response signals of the shared MDU arbiter.
// slave is the arbiter's view; master is the environment (requesters, unit, consumer).
interface mdu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int XLEN    = 64
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*XLEN-1:0] req_a;
  logic [NUM_REQ*XLEN-1:0] req_b;
  logic [NUM_REQ-1:0]      req_m_d;
  logic [XLEN-1:0]         mdu_a;
  logic [XLEN-1:0]         mdu_b;
  logic                    mdu_m_d;
  logic                    mdu_start;
  logic [2*XLEN:0]         mdu_result;
  logic                    mdu_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [2*XLEN:0]         rsp_result;
  logic                    rsp_dz;
  logic                    busy;

  modport slave (
    input  req_valid, req_a, req_b, req_m_d, mdu_result, mdu_ready, rsp_ready,
    output req_ready, mdu_a, mdu_b, mdu_m_d, mdu_start,
           rsp_valid, rsp_id, rsp_result, rsp_dz, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_m_d, mdu_result, mdu_ready, rsp_ready,
    input  req_ready, mdu_a, mdu_b, mdu_m_d, mdu_start,
           rsp_valid, rsp_id, rsp_result, rsp_dz, busy
  );
endinterface

// File: rtl/mdu_arbiter.sv
// Round-robin sharing of one multiply/divide unit among NUM_REQ requesters, with a
// local divide-by-zero bypass and a one-entry tagged response register.
module mdu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int XLEN    = 64
) (
  input  logic         clk,
  input  logic         reset,
  mdu_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [XLEN-1:0]   mdu_a_reg;
  logic [XLEN-1:0]   mdu_b_reg;
  logic              mdu_m_d_reg;
  logic              mdu_start_reg;
  logic              rsp_valid_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [2*XLEN:0]   rsp_result_reg;
  logic              rsp_dz_reg;
  logic              busy_reg;

  logic [XLEN-1:0]   a_arr [NUM_REQ];
  logic [XLEN-1:0]   b_arr [NUM_REQ];
  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   scan_idx;
  logic              accept;
  logic [XLEN-1:0]   grant_a;
  logic [XLEN-1:0]   grant_b;
  logic              grant_m_d;
  logic              grant_dz;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_arr[gi]         = bus.req_a[gi*XLEN +: XLEN];
      assign b_arr[gi]         = bus.req_b[gi*XLEN +: XLEN];
      assign bus.req_ready[gi] = accept && (grant_id == ID_W'(gi));
    end
  endgenerate

  // Scan from the farthest candidate toward rr_ptr+1 so the nearest valid one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (bus.req_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  // No handshake can complete while reset is held.
  assign accept    = (state_reg == IDLE) && grant_valid && !reset;
  assign grant_a   = a_arr[grant_id];
  assign grant_b   = b_arr[grant_id];
  assign grant_m_d = bus.req_m_d[grant_id];
  assign grant_dz  = !grant_m_d && (grant_b == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= ID_W'(NUM_REQ - 1);
      mdu_a_reg      <= '0;
      mdu_b_reg      <= '0;
      mdu_m_d_reg    <= 1'b0;
      mdu_start_reg  <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_dz_reg     <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rr_ptr_reg  <= grant_id;
            rsp_id_reg  <= grant_id;
            mdu_a_reg   <= grant_a;
            mdu_b_reg   <= grant_b;
            mdu_m_d_reg <= grant_m_d;
            busy_reg    <= 1'b1;
            if (grant_dz) begin
              // Quotient saturates to all-ones, remainder is the dividend.
              rsp_result_reg <= {1'b0, grant_a, {XLEN{1'b1}}};
              rsp_dz_reg     <= 1'b1;
              rsp_valid_reg  <= 1'b1;
              state_reg      <= RESP;
            end else begin
              mdu_start_reg <= 1'b1;
              state_reg     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mdu_start_reg <= 1'b0;
          state_reg     <= ARM;
        end
        // The unit's ready may still read high for one cycle after start.
        ARM: state_reg <= WAIT;
        WAIT: begin
          if (bus.mdu_ready) begin
            rsp_result_reg <= bus.mdu_result;
            rsp_dz_reg     <= 1'b0;
            rsp_valid_reg  <= 1'b1;
            state_reg      <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          mdu_start_reg <= 1'b0;
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.mdu_a      = mdu_a_reg;
  assign bus.mdu_b      = mdu_b_reg;
  assign bus.mdu_m_d    = mdu_m_d_reg;
  assign bus.mdu_start  = mdu_start_reg;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_id     = rsp_id_reg;
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_dz     = rsp_dz_reg;
  assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed bench for mdu_arbiter with a behavioural multi-cycle multiply/divide unit.
module tb_mdu_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int XLEN    = 64;

  typedef struct {
    int           id;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         m_d;
    logic [128:0] expv;
    logic         exp_dz;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic unit_init = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   start_cnt = 0;

  mdu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .XLEN(XLEN)) bus ();

  mdu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mdu_start === 1'b1) start_cnt <= start_cnt + 1;

  // Behavioural unit: ready drops on start, result appears 5 cycles later.
  logic [63:0] u_a, u_b;
  logic        u_m_d;
  int          u_cnt;

  function automatic logic [128:0] unit_calc(input logic [63:0] a, input logic [63:0] b,
                                             input logic md);
    logic [127:0] p;
    p = {64'b0, a} * {64'b0, b};
    if (md) return {1'b0, p};
    if (b == 64'd0) return '0;
    return {1'b0, a % b, a / b};
  endfunction

  always @(posedge clk) begin
    if (unit_init) begin
      bus.mdu_ready  <= 1'b1;
      bus.mdu_result <= '0;
      u_cnt          <= 0;
    end else if (bus.mdu_start) begin
      bus.mdu_ready <= 1'b0;
      u_a           <= bus.mdu_a;
      u_b           <= bus.mdu_b;
      u_m_d         <= bus.mdu_m_d;
      u_cnt         <= 5;
    end else if (u_cnt > 1) begin
      u_cnt <= u_cnt - 1;
    end else if (u_cnt == 1) begin
      u_cnt          <= 0;
      bus.mdu_ready  <= 1'b1;
      bus.mdu_result <= unit_calc(u_a, u_b, u_m_d);
    end
  end

  task automatic check(input string nm, input logic [128:0] act, input logic [128:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_timeout", bus.rsp_valid, 1'b1);
  endtask

  task automatic consume_rsp();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_grant();
    int n = 0;
    #1;
    while (bus.req_ready == '0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic load_req(input int id, input logic [63:0] a, input logic [63:0] b,
                          input logic md);
    bus.req_a[id*XLEN +: XLEN] = a;
    bus.req_b[id*XLEN +: XLEN] = b;
    bus.req_m_d[id]            = md;
    bus.req_valid[id]          = 1'b1;
  endtask

  task automatic run_one(input vec_t v);
    int s0;
    @(negedge clk);
    load_req(v.id, v.a, v.b, v.m_d);
    s0 = start_cnt;
    wait_grant();
    check("grant_onehot", bus.req_ready, 129'(1) << v.id);
    if (bus.req_ready[v.id] !== 1'b1) begin
      bus.req_valid[v.id] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid[v.id] = 1'b0;
    check("valid_after_accept", bus.rsp_valid, v.exp_dz);
    wait_rsp();
    check("rsp_id", bus.rsp_id, v.id);
    check("rsp_result", bus.rsp_result, v.expv);
    check("rsp_dz", bus.rsp_dz, v.exp_dz);
    check("start_pulses", start_cnt - s0, v.exp_dz ? 0 : 1);
    $display("[TB] txn id=%0d a=%0h b=%0h m_d=%0b -> rsp_id=%0d result=%0h dz=%0b",
             v.id, v.a, v.b, v.m_d, bus.rsp_id, bus.rsp_result, bus.rsp_dz);
    consume_rsp();
    check("idle_after_rsp", {bus.rsp_valid, bus.busy}, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs[8];
  vec_t cvec[4];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 64'd3, 64'd7, 1'b1, 129'd21, 1'b0};
    vecs[1] = '{2, 64'd100, 64'd7, 1'b0, {1'b0, 64'd2, 64'd14}, 1'b0};
    vecs[2] = '{1, 64'd55, 64'd0, 1'b0, {1'b0, 64'd55, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1};
    vecs[3] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 129'h1_FFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[4] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b0,
                {1'b0, 64'hF, 64'h0FFF_FFFF_FFFF_FFFF}, 1'b0};
    vecs[5] = '{2, 64'd5, 64'd9, 1'b0, {1'b0, 64'd5, 64'd0}, 1'b0};
    vecs[6] = '{3, 64'd0, 64'd0, 1'b0, {1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1};
    vecs[7] = '{1, 64'd12, 64'd0, 1'b1, 129'd0, 1'b0};
    cvec[0] = '{0, 64'd11, 64'd13, 1'b1, 129'd143, 1'b0};
    cvec[1] = '{1, 64'd1000, 64'd33, 1'b0, {1'b0, 64'd10, 64'd30}, 1'b0};
    cvec[2] = '{2, 64'h1_0000_0000, 64'd16, 1'b1, 129'h10_0000_0000, 1'b0};
    cvec[3] = '{3, 64'd77, 64'd7, 1'b0, {1'b0, 64'd0, 64'd11}, 1'b0};

    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_m_d   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state, with every requester asserting valid.
    @(negedge clk);
    unit_init = 1'b0;
    check("rst_req_ready", bus.req_ready, 4'b0000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_id", bus.rsp_id, 2'd0);
    check("rst_rsp_result", bus.rsp_result, 129'd0);
    check("rst_rsp_dz", bus.rsp_dz, 1'b0);
    check("rst_mdu_start", bus.mdu_start, 1'b0);
    check("rst_mdu_ops", {bus.mdu_a, bus.mdu_b, bus.mdu_m_d}, 129'd0);
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_one(vecs[i]);

    // Contention: all four continuously valid, grants rotate from requester 0.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) load_req(i, cvec[i].a, cvec[i].b, cvec[i].m_d);
    for (int g = 0; g < 6; g++) begin
      wait_grant();
      check("rr_grant", bus.req_ready, 129'(1) << (g % NUM_REQ));
      @(posedge clk);
      #1;
      wait_rsp();
      check("rr_rsp_id", bus.rsp_id, g % NUM_REQ);
      check("rr_rsp_result", bus.rsp_result, cvec[g % NUM_REQ].expv);
      $display("[TB] txn grant=%0d rsp_id=%0d result=%0h", g % NUM_REQ, bus.rsp_id,
               bus.rsp_result);
      consume_rsp();
      @(negedge clk);
    end
    bus.req_valid = '0;

    // Backpressure: hold the response for 10 cycles while two others wait.
    @(negedge clk);
    load_req(3, 64'd6, 64'd7, 1'b1);
    wait_grant();
    check("bp_grant", bus.req_ready, 4'b1000);
    @(posedge clk);
    #1;
    bus.req_valid[3] = 1'b0;
    wait_rsp();
    load_req(0, 64'd2, 64'd3, 1'b1);
    load_req(1, 64'd4, 64'd5, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", bus.rsp_valid, 1'b1);
      check("bp_rsp_id", bus.rsp_id, 2'd3);
      check("bp_rsp_result", bus.rsp_result, 129'd42);
      check("bp_no_grant", bus.req_ready, 4'b0000);
      check("bp_no_start", bus.mdu_start, 1'b0);
    end
    $display("[TB] txn backpressure id=%0d result=%0h", bus.rsp_id, bus.rsp_result);
    consume_rsp();
    @(negedge clk);
    wait_grant();
    check("bp_next_grant", bus.req_ready, 4'b0001);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    wait_rsp();
    check("bp_next_id", bus.rsp_id, 2'd0);
    check("bp_next_result", bus.rsp_result, 129'd6);
    consume_rsp();
    bus.req_valid[1] = 1'b0;  // withdrawn before it could be accepted
    repeat (3) @(negedge clk);
    check("withdrawn_idle", {bus.busy, bus.rsp_valid, bus.mdu_start}, 3'b000);

    // Reset while the unit is computing, then a fresh request from requester 2.
    @(negedge clk);
    load_req(1, 64'd5, 64'd5, 1'b1);
    wait_grant();
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy", {bus.busy, bus.rsp_valid}, 2'b10);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    v = '{2, 64'h1_0000_0000, 64'h1_0000_0000, 1'b1, 129'h1_0000_0000_0000_0000, 1'b0};
    run_one(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
